// File: rtl/ec1_controller_if.sv
// Purpose: bundles the controller <-> datapath control and status nets.
// Latency: none, wires only.
// Backpressure: none; the operator key (Enter) is the only pacing input.
// Ports (master = controller side):
//   Enter, IR, AnotZero                    : datapath/operator -> controller
//   IRload, PCload, JNZmux, INmux, Aload,
//   OutE, Halt, state, instr_count         : controller -> datapath/debug
interface ec1_controller_if;
    logic       Enter;
    logic [2:0] IR;
    logic       AnotZero;
    logic       IRload;
    logic       PCload;
    logic       JNZmux;
    logic       INmux;
    logic       Aload;
    logic       OutE;
    logic       Halt;
    logic [2:0] state;
    logic [7:0] instr_count;

    modport master (
        input  Enter, IR, AnotZero,
        output IRload, PCload, JNZmux, INmux, Aload, OutE, Halt, state, instr_count
    );

    modport slave (
        output Enter, IR, AnotZero,
        input  IRload, PCload, JNZmux, INmux, Aload, OutE, Halt, state, instr_count
    );
endinterface

// File: rtl/ec1_controller.sv
// Purpose: Moore FSM sequencing the EC-1 datapath (fetch, decode, execute).
// Latency: 3 cycles per instruction; INPUT waits for an Enter edge (>= 1 cycle).
// Backpressure: INPUT stalls the machine until an Enter pulse; HALT stalls until Reset.
// Ports:
//   clk   : rising-edge clock for all state
//   Reset : synchronous active-high reset (also clears the datapath)
//   ctl   : ec1_controller_if master modport (operator key, opcode, flag, controls, debug)
module ec1_controller (
    input  logic              clk,
    input  logic              Reset,
    ec1_controller_if.master  ctl
);

    localparam logic [2:0] S_START  = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_INPUT  = 3'd3;
    localparam logic [2:0] S_OUTPUT = 3'd4;
    localparam logic [2:0] S_DEC    = 3'd5;
    localparam logic [2:0] S_JNZ    = 3'd6;
    localparam logic [2:0] S_HALT   = 3'd7;

    logic [2:0] r_state;
    logic [2:0] w_next_state;
    logic       r_enter_q;
    logic       r_out_latch;
    logic [7:0] r_instr_count;
    logic       w_enter_pulse;

    // enter_q resets to 1 so a key already held when Reset drops does not
    // look like a fresh press.
    assign w_enter_pulse = ctl.Enter & ~r_enter_q;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_START:  w_next_state = S_FETCH;
            S_FETCH:  w_next_state = S_DECODE;
            S_DECODE: begin
                case (ctl.IR)
                    3'b000:  w_next_state = S_INPUT;
                    3'b001:  w_next_state = S_OUTPUT;
                    3'b010:  w_next_state = S_DEC;
                    3'b011:  w_next_state = S_JNZ;
                    3'b100:  w_next_state = S_HALT;
                    default: w_next_state = S_FETCH;   // unused opcodes act as NOP
                endcase
            end
            S_INPUT:  w_next_state = w_enter_pulse ? S_FETCH : S_INPUT;
            S_OUTPUT: w_next_state = S_FETCH;
            S_DEC:    w_next_state = S_FETCH;
            S_JNZ:    w_next_state = S_FETCH;
            S_HALT:   w_next_state = S_HALT;
            default:  w_next_state = S_START;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state       <= S_START;
            r_enter_q     <= 1'b1;
            r_out_latch   <= 1'b0;
            r_instr_count <= 8'd0;
        end else begin
            r_state   <= w_next_state;
            r_enter_q <= ctl.Enter;
            if (r_state == S_OUTPUT) begin
                r_out_latch <= 1'b1;
            end
            if ((r_state == S_FETCH) && (r_instr_count != 8'hFF)) begin
                r_instr_count <= r_instr_count + 8'd1;
            end
        end
    end

    always_comb begin
        ctl.IRload = 1'b0;
        ctl.PCload = 1'b0;
        ctl.JNZmux = 1'b0;
        ctl.INmux  = 1'b0;
        ctl.Aload  = 1'b0;
        ctl.Halt   = 1'b0;
        case (r_state)
            S_FETCH: begin
                ctl.IRload = 1'b1;
                ctl.PCload = 1'b1;
            end
            S_INPUT: begin
                ctl.INmux = 1'b1;
                ctl.Aload = w_enter_pulse;
            end
            S_DEC: begin
                ctl.Aload = 1'b1;
            end
            S_JNZ: begin
                ctl.JNZmux = 1'b1;
                ctl.PCload = ctl.AnotZero;
            end
            S_HALT: begin
                ctl.Halt = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // OutE rises combinationally in OUTPUT and is then held by the latch.
    assign ctl.OutE        = r_out_latch | (r_state == S_OUTPUT);
    assign ctl.state       = r_state;
    assign ctl.instr_count = r_instr_count;

endmodule
